// File: rtl/matrix_ls_sequencer_pkg.sv
// Shared types and constants for the matrix load/store row sequencer.
// The optional stall counter is enabled with MATRIX_LS_SEQ_PERF_EN.
package matrix_ls_sequencer_pkg;

  localparam int MLS_ROWS   = 4;
  localparam int MLS_ADDR_W = 32;
  localparam int MLS_MREG_W = 5;
  localparam int MLS_ROW_W  = $clog2(MLS_ROWS);

  localparam logic [1:0] MLS_LOAD  = 2'b01;
  localparam logic [1:0] MLS_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } matls_seq_state_t;

  typedef struct packed {
    logic [1:0]            ls;
    logic [MLS_MREG_W-1:0] mat;
    logic [MLS_ROW_W-1:0]  row;
    logic [MLS_ADDR_W-1:0] addr;
  } matls_row_req_t;

  // 00 and 11 are reserved encodings and complete with an error
  function automatic logic mls_ls_legal(input logic [1:0] ls);
    return (ls == MLS_LOAD) || (ls == MLS_STORE);
  endfunction

endpackage

// File: rtl/matrix_ls_sequencer_if.sv
// Request, scratchpad row and completion bundles of the load/store sequencer.
interface matrix_ls_sequencer_if
  import matrix_ls_sequencer_pkg::*;
#(
  parameter int ADDR_W = MLS_ADDR_W,
  parameter int MREG_W = MLS_MREG_W,
  parameter int ROW_W  = MLS_ROW_W
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_ls;
  logic [MREG_W-1:0] req_rd;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;

  logic              sp_req_valid;
  logic              sp_req_ready;
  logic [1:0]        sp_req_ls;
  logic [MREG_W-1:0] sp_req_mat;
  logic [ROW_W-1:0]  sp_req_row;
  logic [ADDR_W-1:0] sp_req_addr;

  logic              done_valid;
  logic [MREG_W-1:0] done_rd;
  logic [1:0]        done_ls;
  logic              done_err;

  modport seq (
    input  req_valid, req_ls, req_rd, req_base, req_stride, sp_req_ready,
    output req_ready, sp_req_valid, sp_req_ls, sp_req_mat, sp_req_row, sp_req_addr,
    output done_valid, done_rd, done_ls, done_err
  );

  modport tb (
    output req_valid, req_ls, req_rd, req_base, req_stride, sp_req_ready,
    input  req_ready, sp_req_valid, sp_req_ls, sp_req_mat, sp_req_row, sp_req_addr,
    input  done_valid, done_rd, done_ls, done_err
  );

endinterface

// File: rtl/matrix_ls_sequencer_addr_gen.sv
// Row counter and row-address accumulator; clear wins over load, load over step.
module matrix_ls_sequencer_addr_gen #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 32,
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] stride_r;

  // address wraps modulo 2^ADDR_W, so negative strides work as two's complement
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row      <= '0;
      addr     <= '0;
      stride_r <= '0;
    end else if (clear) begin
      row <= '0;
    end else if (load) begin
      row      <= '0;
      addr     <= base;
      stride_r <= stride;
    end else if (step) begin
      row  <= row + ROW_W'(1);
      addr <= addr + stride_r;
    end else begin
      row <= row;
    end
  end

  assign last = (row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/matrix_ls_sequencer.sv
// Splits one matrix load/store request into ROWS scratchpad row requests.
// Define MATRIX_LS_SEQ_PERF_EN to add the saturating stall_cnt output.
module matrix_ls_sequencer
  import matrix_ls_sequencer_pkg::*;
#(
  parameter int ROWS   = MLS_ROWS,
  parameter int ADDR_W = MLS_ADDR_W,
  parameter int MREG_W = MLS_MREG_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  matrix_ls_sequencer_if.seq bus,
  output logic               busy
`ifdef MATRIX_LS_SEQ_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int ROW_W = $clog2(ROWS);

  matls_seq_state_t  state;
  logic [1:0]        ls_r;
  logic [MREG_W-1:0] mat_r;
  logic              err_r;
  logic              accept;
  logic              handshake;
  logic              row_last;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;

  assign accept    = (state == IDLE) && bus.req_valid && !flush;
  assign handshake = (state == ISSUE) && bus.sp_req_ready;

  matrix_ls_sequencer_addr_gen #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_addr_gen (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (flush),
    .load   (accept),
    .step   (handshake),
    .base   (bus.req_base),
    .stride (bus.req_stride),
    .row    (row),
    .addr   (addr),
    .last   (row_last)
  );

  // flush overrides every state; a row handshaken in the flush cycle still counts at the scratchpad
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ls_r  <= 2'b00;
      mat_r <= '0;
      err_r <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ls_r  <= bus.req_ls;
            mat_r <= bus.req_rd;
            err_r <= !mls_ls_legal(bus.req_ls);
            state <= mls_ls_legal(bus.req_ls) ? ISSUE : DONE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (handshake && row_last) begin
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE) && !flush;
  assign bus.sp_req_valid = (state == ISSUE);
  assign bus.sp_req_ls    = ls_r;
  assign bus.sp_req_mat   = mat_r;
  assign bus.sp_req_row   = row;
  assign bus.sp_req_addr  = addr;

  assign bus.done_valid = (state == DONE) && !flush;
  assign bus.done_rd    = bus.done_valid ? mat_r : '0;
  assign bus.done_ls    = bus.done_valid ? ls_r : 2'b00;
  assign bus.done_err   = bus.done_valid && err_r;
  assign busy           = (state != IDLE);

`ifdef MATRIX_LS_SEQ_PERF_EN
  // counts backpressured row cycles; survives flush, saturates at all-ones
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= 32'd0;
    end else if (bus.sp_req_valid && !bus.sp_req_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Scoreboard bench for matrix_ls_sequencer (default build or MATRIX_LS_SEQ_PERF_EN).
module tb_matrix_ls_sequencer;
  import matrix_ls_sequencer_pkg::*;

  logic CLK;
  logic RST;
  logic flush;
  logic busy;
`ifdef MATRIX_LS_SEQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  matrix_ls_sequencer_if bus ();

  matrix_ls_sequencer dut (
    .CLK   (CLK),
    .RST   (RST),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
`ifdef MATRIX_LS_SEQ_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks;
  int n_fail;
  matls_row_req_t  sb[$];
  logic [4:0]      exp_rd;
  logic [1:0]      exp_ls;
  logic            exp_err;

  // drives a request at the next negedge (cycle 0) and queues the expected rows
  task automatic drive_req(input logic [1:0] ls, input logic [4:0] rd,
                           input logic [31:0] base, input logic [31:0] stride);
    matls_row_req_t r;
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_ls     = ls;
    bus.req_rd     = rd;
    bus.req_base   = base;
    bus.req_stride = stride;
    exp_rd  = rd;
    exp_ls  = ls;
    exp_err = !((ls == 2'b01) || (ls == 2'b10));
    if (!exp_err) begin
      for (int k = 0; k < MLS_ROWS; k++) begin
        r.ls   = ls;
        r.mat  = rd;
        r.row  = MLS_ROW_W'(k);
        r.addr = base + stride * 32'(k);
        sb.push_back(r);
      end
    end
  endtask

  // runs cycles 1.. after an accept, popping the scoreboard on each row handshake
  task automatic run_rows(input string name, input int stall_row, input int stall_len,
                          input int flush_row, input int exp_done_cyc);
    matls_row_req_t got;
    int n_hs;
    int stalled;
    bit seen_done;
    bit flushed;
    n_hs = 0; stalled = 0; seen_done = 1'b0; flushed = 1'b0;
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      @(negedge CLK);
      bus.req_valid    = 1'b0;
      bus.sp_req_ready = !(bus.sp_req_valid && (int'(bus.sp_req_row) == stall_row) && (stalled < stall_len));
      flush            = bus.sp_req_valid && (int'(bus.sp_req_row) == flush_row) && !flushed;
      #1;
      if (bus.sp_req_valid) begin
        got = {bus.sp_req_ls, bus.sp_req_mat, bus.sp_req_row, bus.sp_req_addr};
        n_checks++;
        if (flushed || sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_row: cycle %0d got %h, required no row", name, c, got);
        end else begin
          if (got !== sb[0]) begin
            n_fail++;
            $display("FAIL %s row_fields: cycle %0d got %h, required %h", name, c, got, sb[0]);
          end
          if (bus.sp_req_ready) begin
            n_checks++;
            if (c != n_hs + 1 + stalled) begin
              n_fail++;
              $display("FAIL %s row_cycle: row %0d at cycle %0d, required %0d", name, n_hs, c, n_hs + 1 + stalled);
            end
            void'(sb.pop_front());
            n_hs++;
          end else begin
            stalled++;
          end
        end
      end
      if (flush) flushed = 1'b1;
      if (bus.done_valid) begin
        seen_done = 1'b1;
        n_checks++;
        if (c != exp_done_cyc) begin
          n_fail++;
          $display("FAIL %s done_cycle: got %0d, required %0d", name, c, exp_done_cyc);
        end
        n_checks++;
        if ({bus.done_rd, bus.done_ls, bus.done_err} !== {exp_rd, exp_ls, exp_err}) begin
          n_fail++;
          $display("FAIL %s done_fields: got rd=%0d ls=%b err=%b, required rd=%0d ls=%b err=%b",
                   name, bus.done_rd, bus.done_ls, bus.done_err, exp_rd, exp_ls, exp_err);
        end
      end
    end
    flush = 1'b0;
    if (exp_done_cyc > 0) begin
      n_checks++;
      if (!seen_done) begin
        n_fail++;
        $display("FAIL %s done_timeout: got no done_valid, required one at cycle %0d", name, exp_done_cyc);
      end
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL %s rows_left: got %0d unissued rows, required 0", name, sb.size());
      end
    end
    sb.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.req_ready, bus.sp_req_valid, bus.done_valid, bus.done_err, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 10000",
               {bus.req_ready, bus.sp_req_valid, bus.done_valid, bus.done_err, busy});
    end
    n_checks++;
    if ({bus.sp_req_ls, bus.sp_req_mat, bus.sp_req_row, bus.sp_req_addr, bus.done_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got ls=%b mat=%0d row=%0d addr=%h, required all zero",
               bus.sp_req_ls, bus.sp_req_mat, bus.sp_req_row, bus.sp_req_addr);
    end
  endtask

  task automatic test_load();
    drive_req(2'b01, 5'd3, 32'h0000_1000, 32'h0000_0040);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_accept: got ready=%b busy=%b, required ready=1 busy=0", bus.req_ready, busy);
    end
    run_rows("load", -1, 0, -1, 5);
    n_checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done_state: got ready=%b busy=%b, required ready=0 busy=1", bus.req_ready, busy);
    end
  endtask

  task automatic test_stall();
    drive_req(2'b10, 5'd7, 32'h0000_2000, 32'h0000_0100);
    run_rows("stall", 1, 3, -1, 8);
`ifdef MATRIX_LS_SEQ_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d, required 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive_req(2'b01, 5'd1, 32'hFFFF_FFF0, 32'h0000_0010);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b, required 1", bus.req_ready);
    end
    run_rows("wrap", -1, 0, -1, 5);
    drive_req(2'b10, 5'd30, 32'h1234_5678, 32'h0000_0000);
    run_rows("stride0", -1, 0, -1, 5);
    drive_req(2'b01, 5'd12, 32'h0000_0100, 32'hFFFF_FFC0);
    run_rows("neg_stride", -1, 0, -1, 5);
  endtask

  task automatic test_illegal();
    logic [1:0] bad [2];
    bad[0] = 2'b11;
    bad[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drive_req(bad[i], 5'd9, 32'h0000_0800, 32'h0000_0004);
      run_rows("illegal", -1, 0, -1, 1);
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_ready_c1: got %b, required 0", bus.req_ready);
      end
      @(negedge CLK);
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_ready_c2: got ready=%b busy=%b, required ready=1 busy=0", bus.req_ready, busy);
      end
    end
  endtask

  task automatic test_flush();
    drive_req(2'b01, 5'd4, 32'h0000_3000, 32'h0000_0008);
    run_rows("flush", -1, 0, 2, -1);
    n_checks++;
    if (busy !== 1'b0 || bus.sp_req_row !== '0) begin
      n_fail++;
      $display("FAIL flush_idle: got busy=%b row=%0d, required busy=0 row=0", busy, bus.sp_req_row);
    end
`ifdef MATRIX_LS_SEQ_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL flush_keeps_stall_cnt: got %0d, required 3", stall_cnt);
    end
`endif
    @(negedge CLK);
    flush          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_ls     = 2'b01;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ready: got %b, required 0", bus.req_ready);
    end
    @(negedge CLK);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.sp_req_valid !== 1'b0 || bus.done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_reject: got busy=%b spv=%b dv=%b, required 0 0 0",
               busy, bus.sp_req_valid, bus.done_valid);
    end
  endtask

  task automatic test_rst();
    drive_req(2'b10, 5'd2, 32'h0000_4000, 32'h0000_0004);
    sb.delete();
    repeat (2) begin
      @(negedge CLK);
      bus.req_valid    = 1'b0;
      bus.sp_req_ready = 1'b1;
    end
    #3;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({bus.sp_req_valid, busy, bus.req_ready, bus.done_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b, required 0010", {bus.sp_req_valid, busy, bus.req_ready, bus.done_valid});
    end
    n_checks++;
    if ({bus.sp_req_ls, bus.sp_req_mat, bus.sp_req_row, bus.sp_req_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_fields: got ls=%b mat=%0d row=%0d addr=%h, required all zero",
               bus.sp_req_ls, bus.sp_req_mat, bus.sp_req_row, bus.sp_req_addr);
    end
`ifdef MATRIX_LS_SEQ_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_stall_cnt: got %0d, required 0", stall_cnt);
    end
`endif
    @(negedge CLK);
    RST = 1'b0;
    drive_req(2'b01, 5'd6, 32'h0000_0500, 32'h0000_0020);
    run_rows("after_rst", -1, 0, -1, 5);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    flush    = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_ls       = 2'b00;
    bus.req_rd       = 5'd0;
    bus.req_base     = 32'd0;
    bus.req_stride   = 32'd0;
    bus.sp_req_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    test_reset();
    test_load();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matrix_ls_sequencer.md
Name: matrix_ls_sequencer

Overview:
- Sits directly downstream of the matrix load/store functional unit.
- Consumes one matrix load/store request: type, destination matrix register, effective base address, stride.
- Breaks the request into ROWS row requests to the scratchpad and holds each row until the scratchpad accepts it.
- Emits a one-cycle completion to writeback/commit when all rows are accepted.

Parameters:
ROWS, 4, rows per matrix; power of two, at least 2
ADDR_W, 32, address and stride width (word_t)
MREG_W, 5, matrix register index width

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
flush  in  1  synchronous abort from the pipeline
req_valid  in  1  FU request valid
req_ready  out  1  sequencer can accept a request
req_ls  in  2  01 = load, 10 = store, 00/11 = illegal
req_rd  in  MREG_W  destination/source matrix register
req_base  in  ADDR_W  effective base address (rs + imm)
req_stride  in  ADDR_W  byte stride between rows
sp_req_valid  out  1  row request valid
sp_req_ready  in  1  scratchpad accepts row (mhit)
sp_req_ls  out  2  latched type
sp_req_mat  out  MREG_W  latched matrix register
sp_req_row  out  log2(ROWS)  current row index
sp_req_addr  out  ADDR_W  current row address
done_valid  out  1  one-cycle completion pulse
done_rd  out  MREG_W  completed register
done_ls  out  2  completed type
done_err  out  1  completion was an illegal type
busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE. All registered fields (ls, mat, row, addr, stride) = 0. req_ready = 1 (if flush = 0). sp_req_valid = 0, done_valid = 0, done_err = 0, busy = 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready = !flush.
  - Accept on req_valid && req_ready: latch ls, rd, base into addr, and stride; set row = 0.
  - Legal ls -> ISSUE. Illegal ls -> DONE with err flag = 1; no scratchpad traffic.
- ISSUE:
  - sp_req_valid = 1. sp_req_addr, sp_req_row, sp_req_ls and sp_req_mat all come from registers and stay stable while !sp_req_ready.
  - On the handshake (sp_req_valid && sp_req_ready): addr <= addr + stride, modulo 2^ADDR_W (wrap, no overflow flag); row <= row + 1.
  - Handshake with row == ROWS-1 -> DONE.
- DONE:
  - done_valid = 1 for exactly one cycle; done_rd, done_ls and done_err come from the latched values. Next state is IDLE.
  - done_* outputs read 0 whenever done_valid = 0.
- Latency with sp_req_ready held high:
  - Accept at cycle 0; rows 0..ROWS-1 at cycles 1..ROWS; done_valid at ROWS+1; next accept at ROWS+2.
  - Illegal type: done_valid at cycle 1.
- req_ready = 0 in ISSUE and DONE; there is no request buffering.
- Stride 0 is legal: all rows go to the same address. A negative stride works through two's-complement wrap.
- flush has highest priority in every state:
  - Next state is IDLE and row = 0.
  - No done_valid is produced; a done_valid already being driven this cycle is suppressed.
  - A flush coinciding with a row handshake still completes that row at the scratchpad, but no further rows are issued.
- RST mid-operation: immediate return to reset values; outstanding rows are lost.

Optional Feature:
- Macro MATRIX_LS_SEQ_PERF_EN.
- When defined:
  - Adds output stall_cnt (32 bits).
  - Increments each cycle that sp_req_valid && !sp_req_ready; saturates at all-ones.
  - Cleared by RST only, not by flush.
- When undefined: the port and its counter logic do not exist; all other behaviour is identical.

Decomposition:
- datapath_pkg gets:
  - matls_seq_state_t enum {IDLE, ISSUE, DONE};
  - constants MLS_LOAD = 2'b01 and MLS_STORE = 2'b10;
  - a packed matls_row_req_t {ls, mat, row, addr}.
- A matching interface file, matrix_ls_seq_if.vh, provides modports seq and tb.
- Sub-module: matls_addr_gen (row counter plus address accumulator, with load/step/clear), instantiated once. Everything else stays in the top-level FSM.

Test Plan:
- Load rd = 3, base = 0x1000, stride = 0x40, sp_req_ready = 1 -> addresses 0x1000/0x1040/0x1080/0x10C0, rows 0..3 in cycles 1..4; done_valid at cycle 5 with done_rd = 3, done_ls = 01.
- Store with sp_req_ready low 3 cycles on row 1 -> row 1 address stable for 4 cycles; done_valid delayed by 3; stall_cnt = 3 when MATRIX_LS_SEQ_PERF_EN is defined.
- Base = 0xFFFFFFF0, stride = 0x10 -> addresses 0xFFFFFFF0, 0x0, 0x10, 0x20; stride 0 -> four identical addresses.
- req_ls = 2'b11 -> no sp_req_valid; done_valid at cycle 1 with done_err = 1; req_ready back high at cycle 2.
- flush asserted during row 2 handshake -> IDLE next cycle, no row 3, no done_valid; flush with req_valid in IDLE -> request not accepted.
- RST asserted asynchronously mid-ISSUE -> all outputs at reset values in the same cycle; a fresh request afterwards starts at row 0.
